// File: rtl/timebase_100m_pkg.sv
// Shared types and helpers for the 100 MHz timebase.
// State encoding plus a width helper for the modulo counters.
package timebase_100m_pkg;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Counter width for a divider; never narrower than one bit.
  function automatic int cnt_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/timebase_100m_mod_counter.sv
// Modulo-MOD counter with clear and enable; wrap marks the last enabled step.
// Ports: clk, rst (async high), en, clr -> cnt, wrap.
import timebase_100m_pkg::*;

module mod_counter #(
  parameter int MOD = 4,
  parameter int W   = cnt_w(MOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign wrap = en & (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timebase_100m.sv
// Reset stretcher plus 1 us / 1 ms / 1 s tick generator on the 100 MHz clock.
// Ports: clk, rst, run, clear -> rst_out, tick_1us, tick_1ms, tick_1s, sec_count.
import timebase_100m_pkg::*;

module timebase_100m #(
  parameter int RST_HOLD = 16,
  parameter int US_DIV   = 100,
  parameter int MS_DIV   = 1000,
  parameter int S_DIV    = 1000,
  parameter int SEC_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  output logic             rst_out,
  output logic             tick_1us,
  output logic             tick_1ms,
  output logic             tick_1s,
  output logic [SEC_W-1:0] sec_count
);

  localparam int HW  = cnt_w(RST_HOLD);
  localparam int USW = cnt_w(US_DIV);
  localparam int MSW = cnt_w(MS_DIV);
  localparam int SW  = cnt_w(S_DIV);

  localparam logic [HW-1:0]  HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [USW-1:0] US_LAST   = USW'(US_DIV - 1);
  localparam logic [MSW-1:0] MS_LAST   = MSW'(MS_DIV - 1);
  localparam logic [SW-1:0]  S_LAST    = SW'(S_DIV - 1);

  state_t        state;
  logic [HW-1:0] hold_cnt;

  logic           en_cnt;
  logic           clr_cnt;
  logic [USW-1:0] cnt_us;
  logic [MSW-1:0] cnt_ms;
  logic [SW-1:0]  cnt_s;
  logic           us_wrap;
  logic           ms_wrap;
  logic           s_wrap;

  // clear outranks run; both ignored while the reset is stretched
  assign en_cnt  = (state == RUN) & run & ~clear;
  assign clr_cnt = (state == RUN) & clear;

  mod_counter #(.MOD(US_DIV)) u_us (
    .clk  (clk),
    .rst  (rst),
    .en   (en_cnt),
    .clr  (clr_cnt),
    .cnt  (cnt_us),
    .wrap (us_wrap)
  );

  mod_counter #(.MOD(MS_DIV)) u_ms (
    .clk  (clk),
    .rst  (rst),
    .en   (us_wrap),
    .clr  (clr_cnt),
    .cnt  (cnt_ms),
    .wrap (ms_wrap)
  );

  mod_counter #(.MOD(S_DIV)) u_s (
    .clk  (clk),
    .rst  (rst),
    .en   (ms_wrap),
    .clr  (clr_cnt),
    .cnt  (cnt_s),
    .wrap (s_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      rst_out   <= 1'b1;
      tick_1us  <= 1'b0;
      tick_1ms  <= 1'b0;
      tick_1s   <= 1'b0;
      sec_count <= '0;
    end else begin
      unique case (state)
        HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          tick_1us <= 1'b0;
          tick_1ms <= 1'b0;
          tick_1s  <= 1'b0;
          if (hold_cnt == HOLD_LAST) begin
            rst_out <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          // wraps are already gated by run/clear through en_cnt
          tick_1us <= us_wrap;
          tick_1ms <= ms_wrap;
          tick_1s  <= s_wrap;
          if (clear) begin
            sec_count <= '0;
          end else if (s_wrap) begin
            sec_count <= sec_count + 1'b1;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

  // counters never leave their modulo range
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (cnt_us <= US_LAST && cnt_ms <= MS_LAST && cnt_s <= S_LAST)
        else $error("counter out of range");
    end
  end

endmodule

// File: tb/tb_timebase_100m.sv
// Randomized self-check of timebase_100m against an arithmetic reference.
// Reference counts enabled edges since clear/reset and derives ticks by modulo.
module tb_timebase_100m;

  localparam int RH  = 5;
  localparam int USD = 4;
  localparam int MSD = 3;
  localparam int SD  = 2;
  localparam int SW  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b1;
  logic          clear = 1'b0;
  logic          rst_out;
  logic          tick_1us;
  logic          tick_1ms;
  logic          tick_1s;
  logic [SW-1:0] sec_count;

  int nvec = 0;
  int nerr = 0;

  // model state: edges since release, enabled edges since clear
  int h = 0;
  int e = 0;
  bit x_us, x_ms, x_s;

  timebase_100m #(
    .RST_HOLD (RH),
    .US_DIV   (USD),
    .MS_DIV   (MSD),
    .S_DIV    (SD),
    .SEC_W    (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .clear     (clear),
    .rst_out   (rst_out),
    .tick_1us  (tick_1us),
    .tick_1ms  (tick_1ms),
    .tick_1s   (tick_1s),
    .sec_count (sec_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("rst_out", int'(rst_out), (h < RH) ? 1 : 0);
    chk("tick_1us", int'(tick_1us), int'(x_us));
    chk("tick_1ms", int'(tick_1ms), int'(x_ms));
    chk("tick_1s", int'(tick_1s), int'(x_s));
    chk("sec_count", int'(sec_count), (e / (USD * MSD * SD)) % (1 << SW));
  endtask

  task automatic model_edge();
    x_us = 0;
    x_ms = 0;
    x_s  = 0;
    if (rst) begin
      h = 0;
      e = 0;
    end else if (h < RH) begin
      h++;
    end else if (clear) begin
      e = 0;
    end else if (run) begin
      e++;
      x_us = (e % USD) == 0;
      x_ms = (e % (USD * MSD)) == 0;
      x_s  = (e % (USD * MSD * SD)) == 0;
    end
  endtask

  task automatic cyc(input bit r, input bit c);
    run   = r;
    clear = c;
    @(posedge clk);
    model_edge();
    #1;
    chk_all();
  endtask

  // assert rst between edges, check its immediate effect, hold, release
  task automatic async_rst(input int n);
    #3;
    rst = 1'b1;
    #1;
    h = 0;
    e = 0;
    x_us = 0;
    x_ms = 0;
    x_s  = 0;
    chk_all();
    repeat (n) cyc(1'b1, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    // 1: reset held, then release with run=1
    repeat (3) cyc(1'b1, 1'b0);
    rst = 1'b0;
    repeat (RH) cyc(1'b1, 1'b0);
    // 2: free run for two seconds
    repeat (48) cyc(1'b1, 1'b0);

    // 3: run 2, pause 10, resume
    async_rst(2);
    repeat (RH) cyc(1'b1, 1'b0);
    repeat (2) cyc(1'b1, 1'b0);
    repeat (10) cyc(1'b0, 1'b0);
    repeat (6) cyc(1'b1, 1'b0);

    // 4: clear when the us counter sits at its last value
    while ((e % USD) != USD - 1) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    repeat (8) cyc(1'b1, 1'b0);

    // 5: reset mid-count
    repeat (7) cyc(1'b1, 1'b0);
    async_rst(1);

    // 6: four full seconds and the wrap of sec_count
    repeat (RH) cyc(1'b1, 1'b0);
    repeat (4 * USD * MSD * SD + 3) cyc(1'b1, 1'b0);

    // random mix of run, clear and occasional reset
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_rst($urandom_range(1, 3));
      end else begin
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 79) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
